// File: rtl/pcie_dma_ctrl.sv
// Single-channel DMA sequencer: splits a programmed copy into 4 KB-safe AXI bursts,
// issuing one read request then one write request per burst and tracking completions.
module pcie_dma_ctrl #(
    parameter int unsigned MAX_BURST_LEN = 16,
    parameter int unsigned ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [15:0]       byte_len_i,
    output logic              done_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              arvalid_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [7:0]        arlen_o,
    input  logic              arready_i,
    input  logic              rvalid_i,
    input  logic              rready_i,
    input  logic              rlast_i,
    input  logic [1:0]        rresp_i,
    output logic              awvalid_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic [7:0]        awlen_o,
    input  logic              awready_i,
    input  logic              bvalid_i,
    output logic              bready_o,
    input  logic [1:0]        bresp_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait,
        StFin
    } state_e;

    localparam logic [13:0] MaxBurst = 14'(MAX_BURST_LEN);

    state_e            state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [13:0]       rem_q;
    logic              done_q;
    logic              err_q;
    logic              arvalid_q;
    logic              awvalid_q;
    logic              bready_q;

    logic [13:0] src_room;
    logic [13:0] dst_room;
    logic [13:0] burst_rem;
    logic [13:0] burst_page;
    logic [13:0] burst;
    logic [13:0] rem_next;
    logic [15:0] burst_bytes;
    logic [7:0]  burst_m1;

    // Beats left before each address reaches the next 4 KB page.
    always_comb begin
        src_room    = (14'd4096 - {2'b00, src_q[11:0]}) >> 2;
        dst_room    = (14'd4096 - {2'b00, dst_q[11:0]}) >> 2;
        burst_rem   = (rem_q < MaxBurst) ? rem_q : MaxBurst;
        burst_page  = (src_room < dst_room) ? src_room : dst_room;
        burst       = (burst_rem < burst_page) ? burst_rem : burst_page;
        rem_next    = rem_q - burst;
        burst_bytes = {burst, 2'b00};
        burst_m1    = 8'(burst - 14'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        src_q  <= {src_addr_i[ADDR_W-1:2], 2'b00};
                        dst_q  <= {dst_addr_i[ADDR_W-1:2], 2'b00};
                        rem_q  <= byte_len_i[15:2];
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                        if (byte_len_i[15:2] == 14'd0) begin
                            state_q <= StFin;
                        end else begin
                            state_q   <= StRdReq;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                StRdReq: begin
                    if (arready_i) begin
                        arvalid_q <= 1'b0;
                        state_q   <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (rvalid_i && rready_i && rlast_i) begin
                        if (rresp_i[1]) begin
                            err_q   <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            awvalid_q <= 1'b1;
                            state_q   <= StWrReq;
                        end
                    end
                end
                StWrReq: begin
                    if (awready_i) begin
                        awvalid_q <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= StWrWait;
                    end
                end
                StWrWait: begin
                    if (bvalid_i) begin
                        bready_q <= 1'b0;
                        if (bresp_i[1]) begin
                            err_q   <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            src_q <= src_q + ADDR_W'(burst_bytes);
                            dst_q <= dst_q + ADDR_W'(burst_bytes);
                            rem_q <= rem_next;
                            if (rem_next == 14'd0) begin
                                state_q <= StFin;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= StRdReq;
                            end
                        end
                    end
                end
                StFin: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Counters are live outside the request phases, so gate them off the bus.
    assign arvalid_o = arvalid_q;
    assign araddr_o  = arvalid_q ? src_q : '0;
    assign arlen_o   = arvalid_q ? burst_m1 : '0;
    assign awvalid_o = awvalid_q;
    assign awaddr_o  = awvalid_q ? dst_q : '0;
    assign awlen_o   = awvalid_q ? burst_m1 : '0;
    assign bready_o  = bready_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign busy_o    = (state_q != StIdle);

    logic unused_bits;
    assign unused_bits = ^{rresp_i[0], bresp_i[0], byte_len_i[1:0], src_addr_i[1:0],
                           dst_addr_i[1:0]};

endmodule

// File: tb/tb_pcie_dma_ctrl.sv
// Randomised bench for pcie_dma_ctrl: a reactive AXI slave, a burst-list reference model
// and a monitor that pops expected AR/AW/done events as the DUT presents them.
module tb_pcie_dma_ctrl;

    localparam int unsigned MaxBurst = 16;
    localparam int unsigned AddrW    = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] byte_len_i = '0;
    logic        done_o, err_o, busy_o;
    logic        arvalid_o, awvalid_o, bready_o;
    logic [31:0] araddr_o, awaddr_o;
    logic [7:0]  arlen_o, awlen_o;
    logic        arready_i, rvalid_i, rready_i, rlast_i, awready_i, bvalid_i;
    logic [1:0]  rresp_i, bresp_i;

    pcie_dma_ctrl #(.MAX_BURST_LEN(MaxBurst), .ADDR_W(AddrW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .byte_len_i(byte_len_i),
        .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
        .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arready_i(arready_i),
        .rvalid_i(rvalid_i), .rready_i(rready_i), .rlast_i(rlast_i), .rresp_i(rresp_i),
        .awvalid_o(awvalid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awready_i(awready_i),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail = 0;
    req_t   exp_ar[$];
    req_t   exp_aw[$];
    bit     exp_done[$];
    int     err_r_idx = -1;
    int     err_b_idx = -1;
    int     ar_hold_req = 0;
    int     xfer_seq = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got an unexpected handshake, required none (t=%0t)", name, $time);
    endtask

    // Reference: walk the copy beat-count by beat-count using the burst rules.
    function automatic void model(input logic [31:0] src, input logic [31:0] dst,
                                  input logic [15:0] len, input int er, input int eb);
        longint rem = longint'(len) >> 2;
        longint s = longint'(src & 32'hFFFF_FFFC);
        longint d = longint'(dst & 32'hFFFF_FFFC);
        longint b;
        bit err = 1'b0;
        int i = 0;
        req_t r;
        while (rem > 0) begin
            b = rem;
            if (MaxBurst < b) b = MaxBurst;
            if ((4096 - s % 4096) / 4 < b) b = (4096 - s % 4096) / 4;
            if ((4096 - d % 4096) / 4 < b) b = (4096 - d % 4096) / 4;
            r.addr = s[31:0];
            r.len = 8'(b - 1);
            exp_ar.push_back(r);
            if (i == er) begin err = 1'b1; break; end
            r.addr = d[31:0];
            exp_aw.push_back(r);
            if (i == eb) begin err = 1'b1; break; end
            s += 4 * b;
            d += 4 * b;
            rem -= b;
            i++;
        end
        exp_done.push_back(err);
    endfunction

    // Reactive AXI slave: decides next-cycle inputs from handshakes seen at the negedge.
    initial begin : slave
        bit s_ar, s_arv, s_r, s_aw, s_b, b_pend;
        logic [7:0] s_len;
        int rd_left, cur_burst, burst_cnt, ar_hold, seen_seq;
        arready_i = 0; rvalid_i = 0; rready_i = 0; rlast_i = 0; rresp_i = 0;
        awready_i = 0; bvalid_i = 0; bresp_i = 0;
        rd_left = 0; cur_burst = 0; burst_cnt = 0; ar_hold = 0; seen_seq = 0; b_pend = 0;
        forever begin
            @(negedge clk);
            s_ar  = arvalid_o && arready_i;
            s_arv = arvalid_o;
            s_len = arlen_o;
            s_r   = rvalid_i && rready_i;
            s_aw  = awvalid_o && awready_i;
            s_b   = bvalid_i && bready_o;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                arready_i = 0; rvalid_i = 0; rready_i = 0; rlast_i = 0; rresp_i = 0;
                awready_i = 0; bvalid_i = 0; bresp_i = 0;
                rd_left = 0; b_pend = 0;
                continue;
            end
            if (seen_seq != xfer_seq) begin
                seen_seq = xfer_seq;
                burst_cnt = 0;
                ar_hold = ar_hold_req;
            end
            if (s_arv && !s_ar && ar_hold > 0) ar_hold--;
            if (s_ar) begin
                rd_left = int'(s_len) + 1;
                cur_burst = burst_cnt;
                burst_cnt++;
            end
            if (s_r && rd_left > 0) rd_left--;
            if (s_aw) b_pend = 1;
            if (s_b) b_pend = 0;
            arready_i = (ar_hold > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (rd_left > 0) begin
                if (!rvalid_i || s_r) rvalid_i = 1'($urandom_range(0, 1));
                rready_i = ($urandom_range(0, 3) != 0);
                rlast_i = rvalid_i && (rd_left == 1);
                // Non-last beats carry junk responses that must be ignored.
                rresp_i = rlast_i ? ((cur_burst == err_r_idx) ? 2'b10 : 2'b00) : 2'($urandom);
            end else begin
                rvalid_i = 0; rlast_i = 0; rresp_i = 0;
                rready_i = 1'($urandom_range(0, 1));
            end
            awready_i = ($urandom_range(0, 2) != 0);
            if (b_pend) begin
                if (!bvalid_i) bvalid_i = 1'($urandom_range(0, 1));
                bresp_i = bvalid_i ? ((cur_burst == err_b_idx) ? 2'b10 : 2'b00) : 2'b00;
            end else begin
                bvalid_i = 0; bresp_i = 0;
            end
        end
    end

    longint     cyc = 0;
    longint     last_evt = 0;
    bit         prev_done = 0;
    bit         hold_v = 0;
    logic [39:0] hold_req = '0;
    req_t       mon_e;
    bit         mon_d;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (start_i && !busy_o) last_evt = cyc;
            if (rvalid_i && rready_i && rlast_i) last_evt = cyc;
            if (bvalid_i && bready_o) last_evt = cyc;
            if (arvalid_o) begin
                if (hold_v) chk("ar_stable", {araddr_o, arlen_o}, hold_req);
                hold_v = !arready_i;
                hold_req = {araddr_o, arlen_o};
            end else begin
                hold_v = 0;
            end
            if (arvalid_o && arready_i) begin
                if (exp_ar.size() == 0) unexpected("ar");
                else begin
                    mon_e = exp_ar.pop_front();
                    chk("ar_addr", araddr_o, mon_e.addr);
                    chk("ar_len", arlen_o, mon_e.len);
                end
            end
            if (awvalid_o && awready_i) begin
                if (exp_aw.size() == 0) unexpected("aw");
                else begin
                    mon_e = exp_aw.pop_front();
                    chk("aw_addr", awaddr_o, mon_e.addr);
                    chk("aw_len", awlen_o, mon_e.len);
                end
            end
            if (done_o && !prev_done) begin
                if (exp_done.size() == 0) unexpected("done");
                else begin
                    mon_d = exp_done.pop_front();
                    chk("done_err", err_o, mon_d);
                    chk("done_latency", cyc - last_evt, 2);
                    chk("done_idle", busy_o, 0);
                end
            end
        end else begin
            hold_v = 0;
        end
        prev_done = done_o;
    end

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        model(s, d, l, err_r_idx, err_b_idx);
        xfer_seq++;
        @(posedge clk);
        #1;
        start_i = 1; src_addr_i = s; dst_addr_i = d; byte_len_i = l;
        @(posedge clk);
        #1;
        start_i = 0; src_addr_i = $urandom; dst_addr_i = $urandom; byte_len_i = 16'($urandom);
        chk("busy_after_start", busy_o, 1);
        chk("ar_rise", arvalid_o, 64'((l >> 2) != 0));
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done_o && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!done_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: done_o=0 after %0d cycles, required 1", t);
            rst_n = 0;
            @(posedge clk);
            #3;
            rst_n = 1;
        end
        repeat (3) @(negedge clk);
        chk("ar_drained", exp_ar.size(), 0);
        chk("aw_drained", exp_aw.size(), 0);
        chk("done_drained", exp_done.size(), 0);
        exp_ar.delete(); exp_aw.delete(); exp_done.delete();
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                       input int er, input int eb);
        err_r_idx = er;
        err_b_idx = eb;
        issue(s, d, l);
        wait_done();
    endtask

    initial begin : stim
        logic [31:0] s, d;
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {done_o, err_o, busy_o, arvalid_o, awvalid_o, bready_o, arlen_o, awlen_o},
            0);
        chk("rst_addr", {araddr_o, awaddr_o}, 0);
        @(posedge clk);
        #3;
        rst_n = 1;

        run(32'h1000, 32'h2000, 16'd64, -1, -1);
        run(32'h1000, 32'h2000, 16'd100, -1, -1);
        run(32'h0FF8, 32'h3000, 16'd32, -1, -1);
        run(32'h0000_4000, 32'h0000_8000, 16'd0, -1, -1);
        run(32'h0000_4000, 32'h0000_8000, 16'd3, -1, -1);
        run(32'h0000_7FF3, 32'h0000_9FFE, 16'd200, -1, -1);

        // AR stall plus an ignored start pulse mid-transfer.
        ar_hold_req = 5;
        err_r_idx = -1;
        err_b_idx = -1;
        issue(32'h5000, 32'h6000, 16'd48);
        ar_hold_req = 0;
        repeat (2) @(posedge clk);
        #1;
        start_i = 1; src_addr_i = 32'hDEAD_0000; dst_addr_i = 32'hBEEF_0000; byte_len_i = 16'd8;
        @(posedge clk);
        #1;
        start_i = 0;
        wait_done();

        run(32'h1000, 32'h2000, 16'd128, -1, 0);
        run(32'h1000, 32'h2000, 16'd128, 1, -1);

        // Reset while waiting for read data.
        err_r_idx = -1;
        err_b_idx = -1;
        issue(32'h1000, 32'h2000, 16'd1024);
        t = 0;
        while (!(arvalid_o && arready_i) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("reach_ar_hs", t < 200, 1);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("midrst_ctrl", {done_o, err_o, busy_o, arvalid_o, awvalid_o, bready_o, arlen_o,
                            awlen_o}, 0);
        chk("midrst_addr", {araddr_o, awaddr_o}, 0);
        exp_ar.delete(); exp_aw.delete(); exp_done.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1;
        run(32'h1000, 32'h2000, 16'd100, -1, -1);

        for (int i = 0; i < 30; i++) begin
            s = {12'($urandom_range(0, 4095)), 8'($urandom), 12'd0};
            d = {12'($urandom_range(0, 4095)), 8'($urandom), 12'd0};
            s[11:0] = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(3900, 4095))
                                                  : 12'($urandom);
            d[11:0] = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(3900, 4095))
                                                  : 12'($urandom);
            run(s, d, 16'($urandom_range(0, 800)),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1,
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_dma_ctrl.md
Name: pcie_dma_ctrl

Overview:
Single-channel DMA sequencer between the APB config block (channel-0 src/dst/len/start/done) and the PCIe TX/RX AXI datapath. It splits a programmed copy into AXI bursts. Each burst is one read request, then waiting for read completion, then one write request, then waiting for the write response. The block issues requests and tracks completions only; write data beats are sourced by the datapath, not by this block.

Parameters:
MAX_BURST_LEN, 16, maximum beats per burst (1..256); beat = 4 bytes
ADDR_W, 32, address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  start pulse from config block
src_addr_i  in  ADDR_W  source byte address, bits[1:0] ignored
dst_addr_i  in  ADDR_W  destination byte address, bits[1:0] ignored
byte_len_i  in  16  transfer length in bytes, bits[1:0] ignored
done_o  out  1  transfer complete, level
err_o  out  1  transfer aborted on error response, level
busy_o  out  1  transfer in progress
arvalid_o  out  1  read request valid
araddr_o  out  ADDR_W  read burst address
arlen_o  out  8  read beats minus 1
arready_i  in  1  read request accepted
rvalid_i / rready_i / rlast_i  in  1 each  read data channel, monitored only
rresp_i  in  2  read response on last beat
awvalid_o  out  1  write request valid
awaddr_o  out  ADDR_W  write burst address
awlen_o  out  8  write beats minus 1
awready_i  in  1  write request accepted
bvalid_i  in  1  write response valid
bready_o  out  1  write response ready
bresp_i  in  2  write response

Behaviour:
- Reset: state IDLE; all outputs 0; address and remaining-beat counters 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE, start_i=1:
  - Latch src/dst with bits[1:0]=0 and rem = byte_len_i[15:2].
  - Clear done_o and err_o.
  - Go to FIN if rem==0, else RD_REQ. arvalid_o rises the cycle after start_i.
- Burst size: burst = min(rem, MAX_BURST_LEN, (4096-src[11:0])>>2, (4096-dst[11:0])>>2). Computed from registered counters. No burst crosses a 4 KB boundary on either side.
- RD_REQ:
  - arvalid_o=1, araddr_o=src, arlen_o=burst-1.
  - Outputs stay stable until arready_i. Move to RD_WAIT on the handshake.
- RD_WAIT:
  - Wait for rvalid_i&rready_i&rlast_i.
  - rresp_i[1]=1 -> set err_o, go to FIN. Otherwise go to WR_REQ.
  - Non-last beats are ignored.
- WR_REQ: awvalid_o=1, awaddr_o=dst, awlen_o=burst-1 (same burst value as the read). Hold until awready_i, then go to WR_WAIT.
- WR_WAIT:
  - bready_o=1. Act on bvalid_i.
  - bresp_i[1]=1 -> set err_o, go to FIN.
  - Otherwise src+=burst*4, dst+=burst*4, rem-=burst. Go to FIN if the new rem==0, else RD_REQ.
- FIN: done_o=1 next cycle, state IDLE. done_o and err_o hold until the next accepted start_i.
- busy_o=1 in every state except IDLE.
- start_i while busy_o=1 is ignored; in-flight parameters are unaffected.
- Config inputs are sampled only on the accepted start cycle; later changes are ignored.
- At most one read or write burst is outstanding at any time.
- Address wrap past 2^ADDR_W is not supported; the 4 KB rule keeps each burst inside one page.
- Async reset mid-transfer returns to IDLE immediately and drops valid/ready outputs with no completion. The bench must not drive stale responses after reset.

Test Plan:
- src=0x1000, dst=0x2000, len=64 -> one AR (0x1000, arlen=15), then one AW (0x2000, awlen=15); done_o=1 one cycle after the B handshake; err_o=0.
- len=100 (25 beats), aligned addresses -> bursts arlen=15 then arlen=8; second araddr=0x1040, second awaddr=0x2040; done_o set after the second B.
- src=0x0FF8, dst=0x3000, len=32 -> first burst 2 beats (arlen=1 at 0x0FF8, awlen=1), second burst 6 beats at src 0x1000 / dst 0x3008.
- len=0 or len=3 -> no arvalid_o or awvalid_o; done_o=1 two cycles after start_i.
- arready_i held low for 5 cycles -> araddr_o/arlen_o stable throughout. start_i pulsed mid-transfer -> no effect on the transfer.
- bresp_i=2'b10 on the first of 2 bursts -> err_o=1, done_o=1, no second AR. rst_n asserted during RD_WAIT -> all outputs 0 immediately; a new start afterwards runs normally.
